time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  Timekeeping controller for the digital clock. Counts prescaler ticks into BCD HH:MM:SS.
//  Sequences a button-driven set mode: select field, then increment it.
//  Drives per-digit enables so the selected field blinks.
//  Sits between the 100 ms prescaler and the 7-seg/LED drivers; its hexs/les feed the drivers.
// PARAMETERS
//  TICKS_PER_SEC  10  tick pulses per second (1 tick = 100 ms)
//  BLINK_TICKS    5   ticks per blink half-period in set mode
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous reset, active-low
//  tick      in   1   1-cycle prescaler pulse, clk domain
//  btn_mode  in   1   mode button level, already synchronised/debounced
//  btn_inc   in   1   increment button level, already synchronised/debounced
//  hexs      out  24  BCD {H1,H0,M1,M0,S1,S0}, 4 bits per digit
//  les       out  6   digit enables, 1 = lit; bit5 = H1 ... bit0 = S0
//  mode      out  2   0 RUN, 1 SET_HH, 2 SET_MM, 3 SET_SS
//  sec_tick  out  1   1-cycle pulse on each RUN-mode second increment
// BEHAVIOUR
//  - All outputs and state are registered.
//  - Reset (rst=0, async): hexs=0, mode=RUN, les=6'b111111, sec_tick=0.
//    Also cleared by reset: sub-counter, blink counter, blink phase=1, button history regs.
//  - Press detect: press = btn & ~btn_q. One press per rising level; a held button gives 1 press.
//  - FSM transitions on mode press: RUN->SET_HH->SET_MM->SET_SS->RUN.
//  - RUN mode:
//    - sub counts ticks 0..TICKS_PER_SEC-1.
//    - On tick with sub==max: sub=0, seconds +1, sec_tick=1 in the same cycle as the hexs update.
//    - Carries: SS 59->00 carries to MM; MM 59->00 carries to HH; HH 23->00, no carry out.
//    - Press latency: 1 clk from the btn rising edge to the register update.
//  - SET_* modes:
//    - Time frozen; sub held at 0; ticks only advance the blink counter.
//    - An inc press adds 1 to the selected field only. Wraps without carry: SS/MM 59->00, HH 23->00.
//    - Leaving SET_SS -> RUN: sub=0, so the first second is a full TICKS_PER_SEC ticks.
//  - Simultaneous mode and inc press in one cycle: mode wins, inc discarded.
//  - tick coincident with a press: both are processed. Exception: the tick completing a second in
//    the same cycle that a mode press leaves RUN is dropped, so time does not change on SET entry.
//  - Blink (SET modes only):
//    - Phase toggles every BLINK_TICKS ticks. The selected 2-digit field's les = {phase,phase};
//      all other les = 1.
//    - Phase forced to 1 and blink counter cleared on entry to each SET state and on every inc press.
//    - In RUN, les = 6'b111111.
//  - BCD invariant: every digit stays 0..9 and H1 stays 0..2.
//    Counting never produces an illegal digit or a time beyond 23:59:59.
//  - Reset mid-set: returns to RUN at 00:00:00 immediately.
// CONFIGURATION
//  TIME_SET_DEC_EN
//    - Defined: adds input btn_dec (1 bit, same rules as btn_inc).
//    - A dec press in a SET mode decrements the field with wrap: SS/MM 00->59, HH 00->23.
//    - inc and dec pressed together: both ignored. dec is ignored in RUN.
//    - Undefined: no port, no decrement logic.
// STRUCTURE
//  - Package clock_pkg: mode encoding constants (MODE_RUN..MODE_SET_SS); BCD limits
//    (SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23).
//  - Sub-module bcd_field: 2-digit BCD register.
//    - Parameter MAX; inputs inc/dec/clr; output carry on MAX->00.
//    - Instantiated 3x (SS, MM, HH); the top holds the FSM, sub/blink counters and press detect.
// TESTING
//  1 Reset, then 10 ticks -> hexs=24'h000001, one sec_tick pulse, les=6'h3F.
//  2 Preload 23:59:59 via set mode, return to RUN, 10 ticks -> hexs=24'h000000, sec_tick once.
//  3 Mode press x1, HH=23, inc press -> HH=00, MM/SS unchanged, mode=1, les[5:4]=2'b11.
//  4 In SET_MM, 5 ticks -> les[3:2]=00; 5 more -> 11; inc mid-blink -> les[3:2]=11 next clk.
//  5 Mode+inc in same cycle from SET_SS -> mode=RUN, SS unchanged; hold btn_inc 100 clk -> 1 increment.
//  6 Drop rst while in SET_HH -> hexs=0, mode=0 asynchronously.
//    With TIME_SET_DEC_EN: SET_SS at 00, dec press -> SS=59.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared mode encoding, BCD limits and display helpers
// for the digital-clock time/set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2,
    MODE_SET_SS = 2'd3
  } mode_e;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  function automatic mode_e next_mode(
    input mode_e m
  );
    mode_e r;
    unique case (m)
      MODE_RUN:    r = MODE_SET_HH;
      MODE_SET_HH: r = MODE_SET_MM;
      MODE_SET_MM: r = MODE_SET_SS;
      MODE_SET_SS: r = MODE_RUN;
      default:     r = MODE_RUN;
    endcase
    return r;
  endfunction

  // Only the selected field follows the blink
  // phase; everything else stays lit.
  function automatic logic [5:0] field_les(
    input mode_e m,
    input logic  ph
  );
    logic [5:0] r;
    unique case (m)
      MODE_RUN:    r = 6'h3F;
      MODE_SET_HH: r = {ph, ph, 4'hF};
      MODE_SET_MM: r = {2'b11, ph, ph, 2'b11};
      MODE_SET_SS: r = {4'hF, ph, ph};
      default:     r = 6'h3F;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_field.sv
// Two-digit BCD register with wrap at MAX.
// Ports: clk_i, rst_ni (async low), clr_i, inc_i, dec_i -> val_o, carry_o.
module bcd_field
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] val_o,
  output logic       carry_o
);

  logic [7:0] val_q;
  logic [7:0] val_d;
  logic [3:0] lo;
  logic [3:0] hi;

  assign lo = val_q[3:0];
  assign hi = val_q[7:4];

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = 8'h00;
    end else if (inc_i) begin
      if (val_q == MAX)
        val_d = 8'h00;
      else if (lo == 4'd9)
        val_d = {hi + 4'd1, 4'd0};
      else
        val_d = {hi, lo + 4'd1};
    end else if (dec_i) begin
      if (val_q == 8'h00)
        val_d = MAX;
      else if (lo == 4'd0)
        val_d = {hi - 4'd1, 4'd9};
      else
        val_d = {hi, lo - 4'd1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      val_q <= 8'h00;
    else
      val_q <= val_d;
  end

  assign val_o   = val_q;
  assign carry_o = inc_i & ~clr_i & (val_q == MAX);

endmodule

// File: rtl/time_set_ctrl.sv
// Timekeeping + button set-mode controller: BCD HH:MM:SS, blink enables.
// Ports: clk, rst(async low), tick, btn_mode, btn_inc[, btn_dec with
// TIME_SET_DEC_EN] -> hexs[23:0], les[5:0], mode[1:0], sec_tick.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int BLINK_TICKS   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
`ifdef TIME_SET_DEC_EN
  input  logic        btn_dec,
`endif
  output logic [23:0] hexs,
  output logic [5:0]  les,
  output logic [1:0]  mode,
  output logic        sec_tick
);

  localparam int SW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW =
    (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SW-1:0] SUB_LAST =
    SW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLK_LAST =
    BW'(BLINK_TICKS - 1);

  mode_e         mode_q, mode_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          ph_q, ph_d;
  logic [5:0]    les_q, les_d;
  logic          stk_q, stk_d;
  logic          mode_bq, inc_bq;

  logic p_mode, p_inc, p_dec;
  logic inc_ev, dec_ev;
  logic run, sec_done, adv;
  logic ss_inc, ss_dec, mm_inc, mm_dec;
  logic hh_inc, hh_dec;
  logic ss_cy, mm_cy, hh_cy_unused;
  logic [7:0] ss_v, mm_v, hh_v;

  assign p_mode = btn_mode & ~mode_bq;
  assign p_inc  = btn_inc & ~inc_bq;

`ifdef TIME_SET_DEC_EN
  logic dec_bq;
  assign p_dec = btn_dec & ~dec_bq;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dec_bq <= 1'b0;
    else
      dec_bq <= btn_dec;
  end
`else
  assign p_dec = 1'b0;
`endif

  // Mode press wins; inc+dec together cancel.
  assign inc_ev = p_inc & ~p_dec & ~p_mode;
  assign dec_ev = p_dec & ~p_inc & ~p_mode;

  assign run      = (mode_q == MODE_RUN);
  assign sec_done = run & tick & (sub_q == SUB_LAST);
  // A second completing as set mode is entered is
  // dropped so the displayed time is frozen as-is.
  assign adv      = sec_done & ~p_mode;

  assign ss_inc = adv |
    ((mode_q == MODE_SET_SS) & inc_ev);
  assign ss_dec = (mode_q == MODE_SET_SS) & dec_ev;
  assign mm_inc = (adv & ss_cy) |
    ((mode_q == MODE_SET_MM) & inc_ev);
  assign mm_dec = (mode_q == MODE_SET_MM) & dec_ev;
  assign hh_inc = (adv & mm_cy) |
    ((mode_q == MODE_SET_HH) & inc_ev);
  assign hh_dec = (mode_q == MODE_SET_HH) & dec_ev;

  bcd_field #(.MAX(SEC_MAX)) u_ss (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (1'b0),
    .inc_i  (ss_inc),
    .dec_i  (ss_dec),
    .val_o  (ss_v),
    .carry_o(ss_cy)
  );

  bcd_field #(.MAX(MIN_MAX)) u_mm (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (1'b0),
    .inc_i  (mm_inc),
    .dec_i  (mm_dec),
    .val_o  (mm_v),
    .carry_o(mm_cy)
  );

  bcd_field #(.MAX(HOUR_MAX)) u_hh (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (1'b0),
    .inc_i  (hh_inc),
    .dec_i  (hh_dec),
    .val_o  (hh_v),
    .carry_o(hh_cy_unused)
  );

  always_comb begin
    mode_d = mode_q;
    sub_d  = sub_q;
    blk_d  = blk_q;
    ph_d   = ph_q;
    if (run) begin
      if (p_mode) begin
        mode_d = next_mode(mode_q);
        sub_d  = '0;
        blk_d  = '0;
        ph_d   = 1'b1;
      end else if (tick) begin
        sub_d = sec_done ? '0 : sub_q + 1'b1;
      end
    end else begin
      // Time is frozen; on exit the first second
      // is a full one.
      sub_d = '0;
      if (tick) begin
        if (blk_q == BLK_LAST) begin
          blk_d = '0;
          ph_d  = ~ph_q;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      if (p_mode) begin
        mode_d = next_mode(mode_q);
        blk_d  = '0;
        ph_d   = 1'b1;
      end else if (inc_ev | dec_ev) begin
        blk_d = '0;
        ph_d  = 1'b1;
      end
    end
    les_d = field_les(mode_d, ph_d);
    stk_d = adv;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_RUN;
      sub_q   <= '0;
      blk_q   <= '0;
      ph_q    <= 1'b1;
      les_q   <= 6'h3F;
      stk_q   <= 1'b0;
      mode_bq <= 1'b0;
      inc_bq  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      sub_q   <= sub_d;
      blk_q   <= blk_d;
      ph_q    <= ph_d;
      les_q   <= les_d;
      stk_q   <= stk_d;
      mode_bq <= btn_mode;
      inc_bq  <= btn_inc;
    end
  end

  assign hexs     = {hh_v, mm_v, ss_v};
  assign les      = les_q;
  assign mode     = mode_q;
  assign sec_tick = stk_q;

endmodule
